// File: rtl/groestl_nonce_scanner_if.sv
// Job, hash-core and golden-nonce signals between the nonce scanner and its environment.
// The master side (job controller plus hash core) drives the job, the hash and golden_ready.
interface groestl_nonce_scanner_if;
  logic         start;
  logic         abort;
  logic [607:0] header;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [63:0]  target;
  logic [647:0] block;
  logic [511:0] hash;
  logic         busy;
  logic         done;
  logic         golden_valid;
  logic [31:0]  golden_nonce;
  logic         golden_ready;
  logic         overflow;
  logic [31:0]  hashes_done;

  modport master (
    output start, abort, header, nonce_start, nonce_end, target, hash, golden_ready,
    input  block, busy, done, golden_valid, golden_nonce, overflow, hashes_done
  );

  modport slave (
    input  start, abort, header, nonce_start, nonce_end, target, hash, golden_ready,
    output block, busy, done, golden_valid, golden_nonce, overflow, hashes_done
  );
endinterface

// File: rtl/groestl_nonce_scanner.sv
// Issues one nonce per cycle to an unrolled Groestl-512 core and queues nonces whose hash meets the target.
// Optional macro NONCE_BSWAP_EN byte-reverses the nonce field inside the block sent to the core.
module groestl_nonce_scanner #(
  parameter int unsigned HASH_LATENCY = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic                    clk,
  input logic                    reset,
  groestl_nonce_scanner_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(HASH_LATENCY + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;

  logic [607:0] header_q;
  logic [31:0]  nonce_q;
  logic [31:0]  nonce_end_q;
  logic [63:0]  target_q;
  logic [647:0] block_q;
  logic [31:0]  hashes_done_q;
  logic         overflow_q;

  logic [HASH_LATENCY:0] tag_valid_q;
  logic [31:0]           tag_nonce_q [HASH_LATENCY+1];

  logic [31:0]    fifo_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;

  logic        busy;
  logic        start_ok;
  logic        abort_ok;
  logic        issue;
  logic        last_nonce;
  logic        exit_live;
  logic        golden;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        drop;
  logic [31:0] nonce_field;
  logic        unused_hash_low;

  assign busy       = (state_q != IDLE);
  assign abort_ok   = bus.abort && busy;
  assign start_ok   = bus.start && !bus.abort && (state_q == IDLE);
  assign issue      = (state_q == SCAN) && !bus.abort;
  assign last_nonce = (nonce_q == nonce_end_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = SCAN;
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (last_nonce) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(HASH_LATENCY);
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The nonce simply stops advancing on the last value, so a range ending at 32'hFFFFFFFF never wraps past it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_q    <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
    end else if (start_ok) begin
      header_q    <= bus.header;
      nonce_q     <= bus.nonce_start;
      nonce_end_q <= bus.nonce_end;
      target_q    <= bus.target;
    end else if (issue && !last_nonce) begin
      nonce_q <= nonce_q + 32'd1;
    end
  end

`ifdef NONCE_BSWAP_EN
  assign nonce_field = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
`else
  assign nonce_field = nonce_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q <= '0;
    end else if (issue) begin
      block_q <= {header_q, nonce_field, 8'h80};
    end
  end

  // Stage 0 lines up with block; stage HASH_LATENCY lines up with the returned hash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid_q <= '0;
    end else if (abort_ok) begin
      tag_valid_q <= '0;
    end else begin
      tag_valid_q <= {tag_valid_q[HASH_LATENCY-1:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    tag_nonce_q[0] <= nonce_q;
    for (int unsigned i = 1; i <= HASH_LATENCY; i++) begin
      tag_nonce_q[i] <= tag_nonce_q[i-1];
    end
  end

  assign exit_live       = tag_valid_q[HASH_LATENCY] && !abort_ok;
  assign golden          = exit_live && (bus.hash[511:448] <= target_q);
  assign unused_hash_low = ^bus.hash[447:0];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = bus.golden_ready && !fifo_empty;
  assign push       = golden && (!fifo_full || pop);
  assign drop       = golden && fifo_full && !pop;

  // When full, a simultaneous pop frees the very slot the push writes into.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q[PTR_W-1:0]] <= tag_nonce_q[HASH_LATENCY];
        wr_ptr_q                    <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q    <= 1'b0;
      hashes_done_q <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (start_ok) begin
        overflow_q <= 1'b0;
      end
      if (start_ok) begin
        hashes_done_q <= '0;
      end else if (exit_live) begin
        hashes_done_q <= hashes_done_q + 32'd1;
      end
    end
  end

  assign bus.block        = block_q;
  assign bus.busy         = busy;
  assign bus.done         = done_d;
  assign bus.golden_valid = !fifo_empty;
  assign bus.golden_nonce = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.overflow     = overflow_q;
  assign bus.hashes_done  = hashes_done_q;

endmodule

// File: tb/tb_groestl_nonce_scanner.sv
// Scoreboard bench for groestl_nonce_scanner; a delay-line stand-in plays the Groestl core.
// Expected golden nonces come from enumerating each job's nonce range against the target.
module tb_groestl_nonce_scanner;
  localparam int unsigned HL = 87;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic reset;

  groestl_nonce_scanner_if bus ();

  groestl_nonce_scanner #(
    .HASH_LATENCY(HL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          nAssert = 0;
  int          nFail = 0;
  int          doneCount = 0;
  int          lastLatency = 0;
  logic [31:0] expQ [$];
  logic [31:0] issuedLog [8];

  int           hashMode = 0;
  logic [607:0] curHeader = '0;
  logic [63:0]  tableBase = '0;
  logic [31:0]  tableNonce = '0;
  logic [31:0]  mixSeed = '0;
  int           readyMode = 0;
  logic         readyLevel = 1'b0;

  logic [511:0] hpipe [HL];

  function automatic logic [31:0] blockNonce(input logic [647:0] b);
    logic [31:0] f;
    f = b[39:8];
`ifdef NONCE_BSWAP_EN
    return {f[7:0], f[15:8], f[23:16], f[31:24]};
`else
    return f;
`endif
  endfunction

  // Top 64 bits of the fake hash for a given nonce under the current job's hash mode.
  function automatic logic [63:0] topFor(input logic [31:0] n);
    logic [31:0] m;
    m = (n * 32'h9E3779B1) ^ mixSeed;
    case (hashMode)
      0:       return 64'h0;
      1:       return (n == 32'h0) ? 64'h0 : 64'h1;
      2:       return tableBase + {32'h0, n - tableNonce};
      default: return (n[1:0] == 2'b00) ? {32'h0, m} : {m | 32'h80000000, 32'h0};
    endcase
  endfunction

  function automatic logic [511:0] hashOf(input logic [647:0] b);
    logic [31:0] n;
    n = blockNonce(b);
    if (b[647:40] != curHeader || b[7:0] != 8'h80) return {64'hFFFFFFFFFFFFFFFF, 448'h0};
    return {topFor(n), {14{n}}};
  endfunction

  function automatic logic [607:0] randHeader();
    logic [607:0] h;
    for (int i = 0; i < 19; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  always @(posedge clk) begin
    hpipe[0] <= hashOf(bus.block);
    for (int i = 1; i < int'(HL); i++) hpipe[i] <= hpipe[i-1];
  end

  assign bus.hash = hpipe[HL-1];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin : readyDriver
    int cyc;
    cyc = 0;
    bus.golden_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (readyMode == 1) bus.golden_ready = ($urandom_range(0, 1) == 1) || (cyc % 4 == 0);
      else bus.golden_ready = readyLevel;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.done) doneCount++;
        if (bus.golden_valid && bus.golden_ready) begin
          if (expQ.size() == 0) checkOutput("golden_unexpected", {63'h0, bus.golden_valid}, 64'h0);
          else checkOutput("golden_nonce", {32'h0, bus.golden_nonce}, {32'h0, expQ.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic startJob(input logic [607:0] hdr, input logic [31:0] ns, input logic [31:0] ne,
                          input logic [63:0] tgt);
    curHeader = hdr;
    @(posedge clk);
    #1;
    bus.header      = hdr;
    bus.nonce_start = ns;
    bus.nonce_end   = ne;
    bus.target      = tgt;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [607:0] hdr, input logic [31:0] ns,
                               input logic [31:0] ne, input logic [63:0] tgt, input int maxKeep,
                               input logic expOvf, input logic waitDrain);
    logic [31:0] count;
    int          kept;
    int          k;
    logic        sawDone;
    count = ne - ns + 32'd1;
    kept  = 0;
    for (int unsigned i = 0; i < count; i++) begin
      logic [31:0] n;
      n = ns + i;
      if (topFor(n) <= tgt && (maxKeep == 0 || kept < maxKeep)) begin
        expQ.push_back(n);
        kept++;
      end
    end
    startJob(hdr, ns, ne, tgt);
    @(negedge clk);
    checkOutput({tag, "_busy"}, {63'h0, bus.busy}, 64'h1);
    sawDone     = 1'b0;
    k           = 0;
    lastLatency = -1;
    while (!sawDone && k < int'(count) + int'(HL) + 20) begin
      @(negedge clk);
      k++;
      if (k <= 8) issuedLog[k-1] = blockNonce(bus.block);
      if (bus.done) begin
        sawDone     = 1'b1;
        lastLatency = k;
      end
    end
    checkOutput({tag, "_done_seen"}, {63'h0, sawDone}, 64'h1);
    @(negedge clk);
    checkOutput({tag, "_hashes_done"}, {32'h0, bus.hashes_done}, {32'h0, count});
    checkOutput({tag, "_busy_after"}, {63'h0, bus.busy}, 64'h0);
    checkOutput({tag, "_overflow"}, {63'h0, bus.overflow}, {63'h0, expOvf});
    if (waitDrain) begin
      k = 0;
      while (bus.golden_valid && k < 200) begin
        @(negedge clk);
        k++;
      end
      checkOutput({tag, "_scoreboard_empty"}, 64'(expQ.size()), 64'h0);
    end
  endtask

  initial begin : stimulus
    logic [607:0] hdr;
    logic [31:0]  ns;
    int           len;
    int           d0;
    int           k;

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.header       = '0;
    bus.nonce_start  = '0;
    bus.nonce_end    = '0;
    bus.target       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_block", {63'h0, |bus.block}, 64'h0);
    checkOutput("reset_busy", {63'h0, bus.busy}, 64'h0);
    checkOutput("reset_done", {63'h0, bus.done}, 64'h0);
    checkOutput("reset_golden_valid", {63'h0, bus.golden_valid}, 64'h0);
    checkOutput("reset_golden_nonce", {32'h0, bus.golden_nonce}, 64'h0);
    checkOutput("reset_overflow", {63'h0, bus.overflow}, 64'h0);
    checkOutput("reset_hashes_done", {32'h0, bus.hashes_done}, 64'h0);

    $display("[TB] single nonce");
    hashMode   = 0;
    readyMode  = 0;
    readyLevel = 1'b1;
    applyStimulus("single", randHeader(), 32'h10, 32'h10, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b1);
    checkOutput("single_done_latency", 64'(lastLatency), 64'(HL + 1));

    $display("[TB] wrap-around");
    hashMode = 1;
    applyStimulus("wrap", randHeader(), 32'hFFFFFFFE, 32'h1, 64'h0, 0, 1'b0, 1'b1);
    checkOutput("wrap_issue0", {32'h0, issuedLog[0]}, 64'hFFFFFFFE);
    checkOutput("wrap_issue1", {32'h0, issuedLog[1]}, 64'hFFFFFFFF);
    checkOutput("wrap_issue2", {32'h0, issuedLog[2]}, 64'h0);
    checkOutput("wrap_issue3", {32'h0, issuedLog[3]}, 64'h1);

    $display("[TB] target boundary");
    hashMode   = 2;
    tableNonce = 32'h500;
    tableBase  = 64'hFF;
    applyStimulus("boundary", randHeader(), 32'h500, 32'h502, 64'h100, 0, 1'b0, 1'b1);

    $display("[TB] overflow");
    hashMode   = 0;
    readyLevel = 1'b0;
    applyStimulus("overflow", randHeader(), 32'd100, 32'd105, 64'hFFFFFFFFFFFFFFFF, int'(FD), 1'b1, 1'b0);
    checkOutput("overflow_held_valid", {63'h0, bus.golden_valid}, 64'h1);
    readyLevel = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.golden_valid && k < 200);
    repeat (3) @(negedge clk);
    checkOutput("overflow_drained", 64'(expQ.size()), 64'h0);
    checkOutput("overflow_valid_low", {63'h0, bus.golden_valid}, 64'h0);
    checkOutput("overflow_sticky", {63'h0, bus.overflow}, 64'h1);

    $display("[TB] full FIFO push with pop");
    readyLevel = 1'b0;
    fork
      applyStimulus("fullpop", randHeader(), 32'h2000, 32'h2007, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b1);
      begin
        int w;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!bus.golden_valid && w < 300);
        checkOutput("fullpop_first_valid", {63'h0, bus.golden_valid}, 64'h1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        readyLevel = 1'b1;
      end
    join

    $display("[TB] random jobs");
    hashMode  = 3;
    readyMode = 1;
    for (int j = 0; j < 4; j++) begin
      mixSeed = $urandom;
      ns      = $urandom;
      len     = $urandom_range(5, 40);
      applyStimulus($sformatf("random%0d", j), randHeader(), ns, ns + 32'(len - 1),
                    {32'h0, 32'($urandom)}, 0, 1'b0, 1'b1);
    end

    $display("[TB] abort");
    readyMode  = 0;
    readyLevel = 1'b1;
    hashMode   = 0;
    hdr        = randHeader();
    startJob(hdr, 32'd0, 32'd999, 64'hFFFFFFFFFFFFFFFF);
    repeat (9) @(posedge clk);
    #1;
    bus.abort       = 1'b1;
    bus.start       = 1'b1;
    bus.nonce_start = 32'd5000;
    bus.nonce_end   = 32'd5010;
    d0              = doneCount;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_next", {63'h0, bus.busy}, 64'h0);
    repeat (200) @(negedge clk);
    checkOutput("abort_start_ignored", {63'h0, bus.busy}, 64'h0);
    checkOutput("abort_no_golden", {63'h0, bus.golden_valid}, 64'h0);
    checkOutput("abort_hashes_done", {32'h0, bus.hashes_done}, 64'h0);
    checkOutput("abort_no_done", 64'(doneCount - d0), 64'h0);

    $display("[TB] reset during drain");
    readyLevel = 1'b0;
    startJob(randHeader(), 32'h77, 32'h79, 64'hFFFFFFFFFFFFFFFF);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.golden_valid && k < 300);
    checkOutput("rst_pre_valid", {63'h0, bus.golden_valid}, 64'h1);
    checkOutput("rst_pre_busy", {63'h0, bus.busy}, 64'h1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_block", {63'h0, |bus.block}, 64'h0);
    checkOutput("rst_async_busy", {63'h0, bus.busy}, 64'h0);
    checkOutput("rst_async_done", {63'h0, bus.done}, 64'h0);
    checkOutput("rst_async_golden_valid", {63'h0, bus.golden_valid}, 64'h0);
    checkOutput("rst_async_golden_nonce", {32'h0, bus.golden_nonce}, 64'h0);
    checkOutput("rst_async_overflow", {63'h0, bus.overflow}, 64'h0);
    checkOutput("rst_async_hashes_done", {32'h0, bus.hashes_done}, 64'h0);
    expQ.delete();
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] recovery after reset");
    readyLevel = 1'b1;
    applyStimulus("recover", randHeader(), 32'h33, 32'h36, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/groestl_nonce_scanner.md
Name: groestl_nonce_scanner

Overview:
- Work-side companion to the fully unrolled Groestl-512 hash core. Drives the core's 648-bit padded block input with one new nonce per cycle.
- Tracks each nonce through a tag line matched to the core's latency. Compares each returned 512-bit hash against a 64-bit target.
- Queues winning ("golden") nonces in a small FIFO with a valid/ready output. Sits between the work/job interface and the hash core.

Parameters:
- HASH_LATENCY, 87, cycles from a block appearing on `block` to its hash appearing on `hash`; must equal the core's pipeline depth.
- FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; latch job inputs and begin scan (ignored while busy=1)
- abort  in  1  one-cycle pulse; stop issuing and discard all in-flight results
- header  in  608  76-byte header prefix, latched on start
- nonce_start  in  32  first nonce, latched on start
- nonce_end  in  32  last nonce (inclusive), latched on start
- target  in  64  unsigned threshold, latched on start
- block  out  648  registered block to the hash core
- hash  in  512  hash returned by the core
- busy  out  1  high in SCAN or DRAIN
- done  out  1  one-cycle pulse when DRAIN completes normally
- golden_valid  out  1  FIFO non-empty
- golden_nonce  out  32  FIFO head
- golden_ready  in  1  pop FIFO head when golden_valid=1
- overflow  out  1  sticky; a golden nonce was dropped because the FIFO was full; cleared by start or reset
- hashes_done  out  32  count of hashes compared in the current job; wraps at 2^32

Behaviour:
- Reset values: block=0, busy=0, done=0, golden_valid=0, golden_nonce=0, overflow=0, hashes_done=0, state=IDLE, tag line valid bits all 0, FIFO empty.
- Block format: block = {header_q, nonce_cur, 8'h80}. `block` is registered, so the nonce issued in cycle N is on `block` in cycle N+1.
- Tag line: HASH_LATENCY-deep shift of {valid, nonce} aligned with `block`. The tag exits in the same cycle its hash is on `hash`.
- Golden condition: tag valid AND hash[511:448] <= target_q, compared as unsigned. The boundary is inclusive: equal to target is golden.
- State IDLE, on start:
  - latch header, nonce_start, nonce_end, target;
  - nonce_cur = nonce_start; clear overflow and hashes_done;
  - go to SCAN.
- State SCAN: each cycle, issue nonce_cur with valid=1.
  - If nonce_cur == nonce_end: go to DRAIN with a counter of HASH_LATENCY.
  - Otherwise: nonce_cur += 1, wrapping 32'hFFFFFFFF to 0.
  - nonce_end < nonce_start is therefore legal and scans through the wrap.
  - nonce_start == nonce_end issues exactly one nonce.
- State DRAIN: issue valid=0 (block keeps its last value). Decrement the counter; at 0 pulse done for one cycle and go to IDLE.
- busy=1 in SCAN and DRAIN.
- abort in SCAN or DRAIN:
  - next state IDLE; clear all tag valid bits; no done pulse;
  - the FIFO and its contents are kept.
  - abort in IDLE: no effect.
- abort and start in the same cycle: abort wins, start is ignored.
- start while busy: ignored.
- hashes_done increments once per exiting valid tag, golden or not.
- FIFO, push and pop in the same cycle:
  - if not full: both happen;
  - if full: both happen, no overflow (the push uses the slot freed by the pop).
- FIFO full, push, no pop: entry dropped, overflow set to 1.
- golden_nonce and golden_valid come straight from registered FIFO state, with no combinational path from golden_ready.
- Reset asserted mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro NONCE_BSWAP_EN.
- When defined: the nonce field in `block` is byte-reversed: {n[7:0], n[15:8], n[23:16], n[31:24]}. The tag line and golden_nonce still carry the un-swapped nonce.
- When undefined: nonce is inserted as-is.

Test Plan:
- Single nonce:
  - Stimulus: start with nonce_start=nonce_end=32'h10, target=64'hFFFFFFFFFFFFFFFF; model returns a delayed hash.
  - Response: one golden_nonce=32'h10; done exactly HASH_LATENCY+1 cycles after SCAN entry; hashes_done=1.
- Wrap-around:
  - Stimulus: nonce_start=32'hFFFFFFFE, nonce_end=32'h1, target=0; model hash top word = 0 only for nonce 0.
  - Response: issue order FFFFFFFE, FFFFFFFF, 0, 1; single golden 32'h0; hashes_done=4.
- Target boundary:
  - Stimulus: target=64'h100; hash tops 64'hFF, 64'h100, 64'h101 for three nonces.
  - Response: first two golden, third not.
- Overflow:
  - Stimulus: 6 consecutive golden hashes, golden_ready=0.
  - Response: 4 entries retained in order; overflow=1. Then hold ready high: drains 4, golden_valid=0; overflow stays 1 until the next start.
- Abort:
  - Stimulus: abort 10 cycles into a 1000-nonce scan, all hashes golden.
  - Response: busy=0 next cycle, no done pulse, no golden pushes after abort. A start in the same cycle as the abort is ignored.
- Reset: assert reset during DRAIN with a non-empty FIFO → all outputs at reset values asynchronously, before the next clock edge.
